// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, writer FSM states and the rectangle command record.
package fb_pkg;

  localparam int unsigned GAME_WIDTH  = 320;
  localparam int unsigned GAME_HEIGHT = 480;
  localparam int unsigned H_START     = 160;
  localparam int unsigned PIXEL_W     = 4;
  localparam int unsigned FB_ADDR_W   = 18;
  localparam int unsigned COORD_W     = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLIP  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fb_wr_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [PIXEL_W-1:0] color;
  } fb_rect_cmd_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clipper: trims a rectangle to the game frame and yields its
// first-row base address; is_null flags rectangles with nothing to draw.
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [COORD_W-1:0]   w,
  input  logic [COORD_W-1:0]   h,
  output logic [COORD_W-1:0]   w_eff,
  output logic [COORD_W-1:0]   h_eff,
  output logic [FB_ADDR_W-1:0] row_base,
  output logic                 is_null
);

  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(GAME_WIDTH);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(GAME_HEIGHT);

  logic [COORD_W-1:0]   w_room;
  logic [COORD_W-1:0]   h_room;
  logic [FB_ADDR_W-1:0] x_ext;
  logic [FB_ADDR_W-1:0] y_ext;

  always_comb begin
    is_null  = (x >= W_LIM) || (y >= H_LIM) || (w == '0) || (h == '0);
    w_room   = '0;
    h_room   = '0;
    w_eff    = '0;
    h_eff    = '0;
    x_ext    = FB_ADDR_W'(x);
    y_ext    = FB_ADDR_W'(y);
    // Subtractions only once x/y are known in range, so they never wrap.
    if (!is_null) begin
      w_room = W_LIM - x;
      h_room = H_LIM - y;
      w_eff  = (w < w_room) ? w : w_room;
      h_eff  = (h < h_room) ? h : h_room;
    end
    // y*320 + x without a multiplier.
    row_base = (y_ext << 8) + (y_ext << 6) + x_ext;
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: accepts a command, clips it to the frame and streams
// one write per clock into frame-buffer port A in row-major order.
module fb_rect_writer
  import fb_pkg::*;
(
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [COORD_W-1:0]   cmd_x,
  input  logic [COORD_W-1:0]   cmd_y,
  input  logic [COORD_W-1:0]   cmd_w,
  input  logic [COORD_W-1:0]   cmd_h,
  input  logic [PIXEL_W-1:0]   cmd_color,
  input  logic                 abort,
  output logic [FB_ADDR_W-1:0] FB_Addra,
  output logic [PIXEL_W-1:0]   FB_dina,
  output logic                 FB_ENA,
  output logic                 FB_WEA,
  output logic                 busy,
  output logic                 done
);

  localparam logic [FB_ADDR_W-1:0] ROW_STRIDE = FB_ADDR_W'(GAME_WIDTH);

  fb_wr_state_t         state_q, state_d;
  fb_rect_cmd_t         cmd_q, cmd_d;
  logic [COORD_W-1:0]   w_eff_q, w_eff_d;
  logic [COORD_W-1:0]   h_eff_q, h_eff_d;
  logic [COORD_W-1:0]   col_q, col_d;
  logic [COORD_W-1:0]   row_q, row_d;
  logic [FB_ADDR_W-1:0] row_base_q, row_base_d;

  logic [COORD_W-1:0]   clip_w;
  logic [COORD_W-1:0]   clip_h;
  logic [FB_ADDR_W-1:0] clip_base;
  logic                 clip_null;
  logic                 last_col;
  logic                 last_row;

  fb_rect_clip u_clip (
    .x        (cmd_q.x),
    .y        (cmd_q.y),
    .w        (cmd_q.w),
    .h        (cmd_q.h),
    .w_eff    (clip_w),
    .h_eff    (clip_h),
    .row_base (clip_base),
    .is_null  (clip_null)
  );

  // Outputs decode straight from state so an async reset kills FB_WEA at once.
  assign cmd_ready = (state_q == IDLE) && axi_aresetn;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign FB_ENA    = (state_q == WRITE);
  assign FB_WEA    = FB_ENA;
  assign FB_Addra  = row_base_q + FB_ADDR_W'(col_q);
  assign FB_dina   = cmd_q.color;

  assign last_col  = (col_q == w_eff_q - COORD_W'(1));
  assign last_row  = (row_q == h_eff_q - COORD_W'(1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    w_eff_d    = w_eff_q;
    h_eff_d    = h_eff_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cmd_d.x     = cmd_x;
          cmd_d.y     = cmd_y;
          cmd_d.w     = cmd_w;
          cmd_d.h     = cmd_h;
          cmd_d.color = cmd_color;
          state_d     = CLIP;
        end
      end
      CLIP: begin
        if (clip_null) begin
          state_d = DONE;
        end else begin
          w_eff_d    = clip_w;
          h_eff_d    = clip_h;
          row_base_d = clip_base;
          col_d      = '0;
          row_d      = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        // The strobe shown this cycle always lands; abort only stops the next one.
        if (abort || (last_col && last_row)) begin
          state_d = DONE;
        end else if (last_col) begin
          col_d      = '0;
          row_d      = row_q + COORD_W'(1);
          row_base_d = row_base_q + ROW_STRIDE;
        end else begin
          col_d = col_q + COORD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      w_eff_q    <= '0;
      h_eff_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      w_eff_q    <= w_eff_d;
      h_eff_q    <= h_eff_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
    end
  end

endmodule
